ws2812b_chain_driver: RTL and testbench

- Parametrised successor to the single-output WS2812B path in tt_um_faramire_ws2812b_wrapper.
- Holds a frame buffer of NUM_LEDS 24-bit GRB pixels and serialises the whole chain on one data pin on a start pulse, then holds the latch/reset low time.
- Adds programmable global brightness, chain length, bit timing, and done/busy handshaking.
- Sits between the encoder/colour-selection logic (writer) and the LED output pin in the top-level wrapper.

---
 rtl/ws2812b_chain_driver.sv | 190 +++++++++++++++++++
 tb/tb_ws2812b_chain_driver.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_chain_driver.sv
// ws2812b_chain_driver
// Frame-buffered WS2812B chain serialiser. A start pulse shifts every pixel out
// MSB first (G, R, B) on dout, scaled by a brightness shift captured at start,
// then holds dout low for the latch time and pulses done.
module ws2812b_chain_driver #(
   parameter int NUM_LEDS = 8,
   parameter int T0H      = 20,
   parameter int T1H      = 40,
   parameter int TBIT     = 63,
   parameter int TRES     = 2500,
   localparam int ADDR_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [23:0]       wr_data,
   input  logic              start,
   input  logic [2:0]        bright,
   output logic              dout,
   output logic              busy,
   output logic              done
);

   // One counter serves both bit timing and latch timing, so size it for the larger.
   localparam int CYC_MAX = (TRES > TBIT) ? TRES : TBIT;
   localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

   localparam logic [CYC_W-1:0]  T0H_C     = CYC_W'(T0H);
   localparam logic [CYC_W-1:0]  T1H_C     = CYC_W'(T1H);
   localparam logic [CYC_W-1:0]  TBIT_LAST = CYC_W'(TBIT - 1);
   localparam logic [CYC_W-1:0]  TRES_LAST = CYC_W'(TRES - 1);
   localparam logic [ADDR_W-1:0] LAST_LED  = ADDR_W'(NUM_LEDS - 1);
   localparam logic [ADDR_W:0]   LED_COUNT = (ADDR_W + 1)'(NUM_LEDS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [CYC_W-1:0]  cyc_r;
   logic [CYC_W-1:0]  cyc_s;
   logic [23:0]       sr_r;
   logic [23:0]       sr_s;
   logic [4:0]        bit_idx_r;
   logic [4:0]        bit_idx_s;
   logic [ADDR_W-1:0] led_idx_r;
   logic [ADDR_W-1:0] led_idx_s;
   logic [ADDR_W-1:0] nxt_idx_s;
   logic [2:0]        bright_r;
   logic [2:0]        bright_s;
   logic              dout_r;
   logic              dout_s;
   logic              busy_r;
   logic              busy_s;
   logic              done_r;
   logic              done_s;
   logic              wr_ok_s;
   logic [23:0]       pix_buf_r [NUM_LEDS];

   // Per-channel logical right shift; bright=7 keeps only each channel's MSB.
   function automatic logic [23:0] scale_pixel(input logic [23:0] pix, input logic [2:0] sh);
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
      g = pix[23:16] >> sh;
      r = pix[15:8]  >> sh;
      b = pix[7:0]   >> sh;
      return {g, r, b};
   endfunction

   // Zero-extend the address so a power-of-two NUM_LEDS still compares correctly.
   assign wr_ok_s = wr_en && ({1'b0, wr_addr} < LED_COUNT);

   // Frame buffer: in-range writes are accepted in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LEDS; i++) begin
            pix_buf_r[i] <= 24'd0;
         end
      end else if (wr_ok_s) begin
         pix_buf_r[wr_addr] <= wr_data;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, datapath next values and next output values.
   always_comb begin
      state_s   = state_r;
      cyc_s     = cyc_r;
      sr_s      = sr_r;
      bit_idx_s = bit_idx_r;
      led_idx_s = led_idx_r;
      bright_s  = bright_r;
      done_s    = 1'b0;
      nxt_idx_s = led_idx_r + 1'b1;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s   = ST_SEND;
               bright_s  = bright;
               sr_s      = scale_pixel(pix_buf_r[0], bright);
               led_idx_s = '0;
               bit_idx_s = 5'd23;
               cyc_s     = '0;
            end else begin
               state_s   = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (cyc_r == TBIT_LAST) begin
               cyc_s = '0;
               if (bit_idx_r != 5'd0) begin
                  sr_s      = {sr_r[22:0], 1'b0};
                  bit_idx_s = bit_idx_r - 5'd1;
               end else if (led_idx_r != LAST_LED) begin
                  // Pixel is sampled here: writes on this same edge land next frame.
                  led_idx_s = nxt_idx_s;
                  sr_s      = scale_pixel(pix_buf_r[nxt_idx_s], bright_r);
                  bit_idx_s = 5'd23;
               end else begin
                  state_s   = ST_LATCH;
               end
            end else begin
               cyc_s = cyc_r + 1'b1;
            end
         end
         ST_LATCH: begin
            if (cyc_r == TRES_LAST) begin
               state_s = ST_IDLE;
               cyc_s   = '0;
               done_s  = 1'b1;
            end else begin
               cyc_s   = cyc_r + 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cyc_s   = '0;
         end
      endcase
      // Outputs are computed from next values so the registered copies line up
      // with the state they describe.
      busy_s = (state_s != ST_IDLE);
      if (state_s == ST_SEND) begin
         dout_s = (cyc_s < (sr_s[23] ? T1H_C : T0H_C));
      end else begin
         dout_s = 1'b0;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_r     <= '0;
         sr_r      <= 24'd0;
         bit_idx_r <= 5'd0;
         led_idx_r <= '0;
         bright_r  <= 3'd0;
         dout_r    <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         cyc_r     <= cyc_s;
         sr_r      <= sr_s;
         bit_idx_r <= bit_idx_s;
         led_idx_r <= led_idx_s;
         bright_r  <= bright_s;
         dout_r    <= dout_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   assign dout = dout_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_ws2812b_chain_driver.sv
// tb_ws2812b_chain_driver
// Table-driven frame checks, hand-written corner sequences and randomized
// traffic against a per-cycle behavioural model of the chain driver.
`timescale 1ns/1ps
module tb_ws2812b_chain_driver;

   localparam int N        = 2;
   localparam int T0H      = 2;
   localparam int T1H      = 4;
   localparam int TBIT     = 6;
   localparam int TRES     = 10;
   localparam int SEND_LEN = N * 24 * TBIT;
   localparam int TOTAL    = SEND_LEN + TRES;
   localparam int N3       = 3;
   localparam int TOTAL3   = N3 * 24 * TBIT + TRES;
   localparam int TOTAL_D  = 8 * 24 * 63 + 2500;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        wr_addr = 1'b0;
   logic [23:0] wr_data = 24'd0;
   logic        start = 1'b0;
   logic [2:0]  bright = 3'd0;
   logic        dout, busy, done;

   logic        wr_en3 = 1'b0;
   logic [1:0]  wr_addr3 = 2'd0;
   logic        start3 = 1'b0;
   logic        dout3, busy3, done3;

   logic        start_d = 1'b0;
   logic        dout_d, busy_d, done_d;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_on = 1'b0;

   ws2812b_chain_driver #(.NUM_LEDS(N), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRES(TRES)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .bright(bright), .dout(dout), .busy(busy), .done(done));

   ws2812b_chain_driver #(.NUM_LEDS(N3), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRES(TRES)) dut3 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data),
      .start(start3), .bright(bright), .dout(dout3), .busy(busy3), .done(done3));

   ws2812b_chain_driver dut_d (
      .clk(clk), .rst_n(rst_n), .wr_en(1'b0), .wr_addr(3'd0), .wr_data(24'd0),
      .start(start_d), .bright(3'd0), .dout(dout_d), .busy(busy_d), .done(done_d));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   logic [23:0] m_buf  [N];
   logic [23:0] m_snap [N];
   logic        m_active, m_done;
   int          m_t;
   logic [2:0]  m_shift;
   logic        exp_dout, exp_busy, exp_done;
   int          e_bnum, e_phase;
   logic [23:0] e_pix;

   function automatic logic [23:0] dim(input logic [23:0] p, input logic [2:0] s);
      int d;
      int g, r, b;
      d = 1 << s;
      g = int'(p[23:16]) / d;
      r = int'(p[15:8]) / d;
      b = int'(p[7:0]) / d;
      return {8'(g), 8'(r), 8'(b)};
   endfunction

   // m_t = cycles since the accepted start edge; pixel k is sampled when m_t reaches k*24*TBIT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_t      <= 0;
         m_shift  <= 3'd0;
         for (int i = 0; i < N; i++) begin
            m_buf[i]  <= 24'd0;
            m_snap[i] <= 24'd0;
         end
      end else begin
         m_done <= 1'b0;
         if (!m_active) begin
            if (start) begin
               m_active  <= 1'b1;
               m_t       <= 0;
               m_shift   <= bright;
               m_snap[0] <= dim(m_buf[0], bright);
            end
         end else if (m_t == TOTAL - 1) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
         end else begin
            m_t <= m_t + 1;
            if (((m_t + 1) % (24 * TBIT) == 0) && ((m_t + 1) / (24 * TBIT) < N))
               m_snap[(m_t + 1) / (24 * TBIT)] <= dim(m_buf[(m_t + 1) / (24 * TBIT)], m_shift);
         end
         if (wr_en && (int'(wr_addr) < N)) m_buf[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      exp_busy = m_active;
      exp_done = m_done;
      exp_dout = 1'b0;
      e_bnum   = 0;
      e_phase  = 0;
      e_pix    = 24'd0;
      if (m_active && (m_t < SEND_LEN)) begin
         e_bnum   = m_t / TBIT;
         e_phase  = m_t % TBIT;
         e_pix    = m_snap[e_bnum / 24];
         exp_dout = (e_phase < (e_pix[23 - (e_bnum % 24)] ? T1H : T0H));
      end
   end

   always @(negedge clk) begin
      if (chk_on) check("cycle_model", {61'd0, dout, busy, done}, {61'd0, exp_dout, exp_busy, exp_done});
   end

   // ---------------- directed helpers ----------------
   task automatic wr(input logic a, input logic [23:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic run_frame(input int mid_j, input logic mid_start, input logic mid_wr,
                            input logic mid_addr, input logic [23:0] mid_data,
                            input logic [2:0] mid_br, input logic chain,
                            output logic [47:0] bits, output int nbits, output int nbad,
                            output int busy_cnt, output int done_at, output logic busy_first);
      int run;
      run = 0; bits = 48'd0; nbits = 0; nbad = 0; busy_cnt = 0; done_at = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      busy_first = busy;
      for (int j = 0; j < TOTAL + 20; j++) begin
         if (dout) begin
            run++;
         end else if (run > 0) begin
            if (run == T1H) begin bits = {bits[46:0], 1'b1}; nbits++; end
            else if (run == T0H) begin bits = {bits[46:0], 1'b0}; nbits++; end
            else nbad++;
            run = 0;
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_at = j + 1;
            if (chain) start = 1'b1;
            break;
         end
         if (j == mid_j) begin
            start = mid_start; wr_en = mid_wr; wr_addr = mid_addr; wr_data = mid_data; bright = mid_br;
         end else if (j == mid_j + 1) begin
            start = 1'b0; wr_en = 1'b0;
         end
         cyc();
      end
   endtask

   typedef struct {
      logic        wr_pre;
      logic [23:0] p0, p1;
      logic [2:0]  br;
      int          mid_j;
      logic        mid_start, mid_wr, mid_addr;
      logic [23:0] mid_data;
      logic [2:0]  mid_br;
      logic        chain;
      logic [23:0] e0, e1;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   initial begin
      logic [47:0] bits;
      int nbits, nbad, busy_cnt, done_at, ones, cnt;
      logic busy_first;

      vecs[0]  = '{1'b0, 24'h000000, 24'h000000, 3'd0, -1,  1'b0, 1'b0, 1'b0, 24'h000000, 3'd0, 1'b0, 24'h000000, 24'h000000};
      vecs[1]  = '{1'b1, 24'hA50000, 24'h0000FF, 3'd0, -1,  1'b0, 1'b0, 1'b0, 24'h000000, 3'd0, 1'b0, 24'hA50000, 24'h0000FF};
      vecs[2]  = '{1'b1, 24'hFF80FF, 24'h000000, 3'd3, 50,  1'b0, 1'b0, 1'b0, 24'h000000, 3'd0, 1'b0, 24'h1F101F, 24'h000000};
      vecs[3]  = '{1'b1, 24'h123456, 24'hABCDEF, 3'd7, -1,  1'b0, 1'b0, 1'b0, 24'h000000, 3'd7, 1'b0, 24'h000000, 24'h010101};
      vecs[4]  = '{1'b1, 24'hFFFFFF, 24'h800001, 3'd1, -1,  1'b0, 1'b0, 1'b0, 24'h000000, 3'd1, 1'b0, 24'h7F7F7F, 24'h400000};
      vecs[5]  = '{1'b1, 24'h0F0F0F, 24'hF0F0F0, 3'd0, 100, 1'b1, 1'b0, 1'b0, 24'h000000, 3'd0, 1'b0, 24'h0F0F0F, 24'hF0F0F0};
      vecs[6]  = '{1'b1, 24'h111111, 24'h222222, 3'd0, 20,  1'b0, 1'b1, 1'b1, 24'h123456, 3'd0, 1'b0, 24'h111111, 24'h123456};
      vecs[7]  = '{1'b1, 24'h111111, 24'h222222, 3'd0, 143, 1'b0, 1'b1, 1'b1, 24'h333333, 3'd0, 1'b0, 24'h111111, 24'h222222};
      vecs[8]  = '{1'b1, 24'h111111, 24'h222222, 3'd0, 142, 1'b0, 1'b1, 1'b1, 24'h444444, 3'd0, 1'b0, 24'h111111, 24'h444444};
      vecs[9]  = '{1'b1, 24'hAAAAAA, 24'h555555, 3'd0, 200, 1'b0, 1'b1, 1'b0, 24'h0F0F0F, 3'd0, 1'b1, 24'hAAAAAA, 24'h555555};
      vecs[10] = '{1'b0, 24'h000000, 24'h000000, 3'd0, -1,  1'b0, 1'b0, 1'b0, 24'h000000, 3'd0, 1'b0, 24'h0F0F0F, 24'h555555};

      // Reset held with inputs toggling: outputs must stay low.
      rst_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         start   = 1'($urandom_range(0, 1));
         wr_addr = 1'($urandom_range(0, 1));
         wr_data = 24'($urandom);
         bright  = 3'($urandom_range(0, 7));
         cyc();
         chk_on = 1'b1;
      end
      check("rst_dout", {63'd0, dout}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      wr_en = 1'b0; start = 1'b0; bright = 3'd0;
      rst_n = 1'b1;
      repeat (3) cyc();

      // Table-driven frames.
      for (int k = 0; k < NV; k++) begin
         if (vecs[k].wr_pre) begin
            wr(1'b0, vecs[k].p0);
            wr(1'b1, vecs[k].p1);
         end
         bright = vecs[k].br;
         run_frame(vecs[k].mid_j, vecs[k].mid_start, vecs[k].mid_wr, vecs[k].mid_addr,
                   vecs[k].mid_data, vecs[k].mid_br, vecs[k].chain,
                   bits, nbits, nbad, busy_cnt, done_at, busy_first);
         check($sformatf("v%0d_led0", k), {40'd0, bits[47:24]}, {40'd0, vecs[k].e0});
         check($sformatf("v%0d_led1", k), {40'd0, bits[23:0]}, {40'd0, vecs[k].e1});
         check($sformatf("v%0d_nbits", k), 64'(nbits), 64'd48);
         check($sformatf("v%0d_badpulse", k), 64'(nbad), 64'd0);
         check($sformatf("v%0d_busylen", k), 64'(busy_cnt), 64'(TOTAL));
         check($sformatf("v%0d_done_at", k), 64'(done_at), 64'(TOTAL + 1));
         check($sformatf("v%0d_busy_first", k), {63'd0, busy_first}, 64'd1);
         if (!vecs[k].chain) repeat (3) cyc();
      end

      // Reset mid-frame at bit 10 of LED 0: outputs drop at once, buffer clears.
      wr(1'b0, 24'hFFFFFF);
      wr(1'b1, 24'hFFFFFF);
      bright = 3'd0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (60) cyc();
      check("midrst_pre_dout", {63'd0, dout}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_dout", {63'd0, dout}, 64'd0);
      check("midrst_busy", {63'd0, busy}, 64'd0);
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      run_frame(-1, 1'b0, 1'b0, 1'b0, 24'd0, 3'd0, 1'b0, bits, nbits, nbad, busy_cnt, done_at, busy_first);
      check("postrst_frame", {16'd0, bits}, 64'd0);
      check("postrst_busylen", 64'(busy_cnt), 64'(TOTAL));
      repeat (3) cyc();

      // Randomized traffic, checked cycle by cycle against the model.
      for (int i = 0; i < 4000; i++) begin
         wr_en   = 1'($urandom_range(0, 3) == 0);
         wr_addr = 1'($urandom_range(0, 1));
         wr_data = 24'($urandom);
         start   = 1'($urandom_range(0, 29) == 0);
         bright  = 3'($urandom_range(0, 7));
         cyc();
      end
      wr_en = 1'b0; start = 1'b0; bright = 3'd0;
      repeat (TOTAL + 5) cyc();

      // Out-of-range write on a 3-LED chain is dropped; in-range index 2 lands.
      wr_en3 = 1'b1; wr_addr3 = 2'd3; wr_data = 24'hFFFFFF; cyc();
      wr_addr3 = 2'd2; wr_data = 24'h00000F; cyc();
      wr_en3 = 1'b0;
      start3 = 1'b1; cyc(); start3 = 1'b0;
      ones = 0; cnt = 0; busy_cnt = 0;
      begin
         int run3;
         run3 = 0;
         for (int j = 0; j < TOTAL3 + 20; j++) begin
            if (dout3) run3++;
            else if (run3 > 0) begin
               if (run3 == T1H) ones++;
               cnt++;
               run3 = 0;
            end
            if (busy3) busy_cnt++;
            cyc();
         end
      end
      check("oor_ones", 64'(ones), 64'd4);
      check("oor_bits", 64'(cnt), 64'd72);
      check("n3_busylen", 64'(busy_cnt), 64'(TOTAL3));

      // Default-parameter chain: busy length and a single done pulse.
      start_d = 1'b1; cyc(); start_d = 1'b0;
      busy_cnt = 0; cnt = 0;
      for (int j = 0; j < TOTAL_D + 50; j++) begin
         if (busy_d) busy_cnt++;
         if (done_d) cnt++;
         cyc();
      end
      check("def_busylen", 64'(busy_cnt), 64'(TOTAL_D));
      check("def_done_cnt", 64'(cnt), 64'd1);
      check("def_idle_busy", {63'd0, busy_d}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time bound.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
